// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state type and HD44780/PCF8574 constants for lcd_frame_writer
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT_NIB,
    ST_INIT_CMD,
    ST_FRAME,
    ST_GAP
  } lcd_state_e;

  localparam int RS_BIT = 0;
  localparam int RW_BIT = 1;
  localparam int EN_BIT = 2;
  localparam int BL_BIT = 3;

  localparam logic [7:0] CMD_FUNC_4B2L = 8'h28;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] DDRAM_L1      = 8'h80;
  localparam logic [7:0] DDRAM_L2      = 8'hC0;

  // Char k sits MSB-first in the row; NUL renders as a blank.
  function automatic logic [7:0] row_char(input logic [127:0] row, input logic [3:0] k);
    logic [7:0] c;
    c = row[{~k, 3'b000} +: 8];
    return (c == 8'h00) ? 8'h20 : c;
  endfunction

endpackage

// File: rtl/lcd_byte_splitter.sv
// rtl/lcd_byte_splitter.sv - turns one LCD byte or init nibble into EN-strobed PCF8574 port bytes
module lcd_byte_splitter
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_byte_i,
  input  logic       req_rs_i,
  input  logic       req_nib_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  output logic [7:0] port_data_o,
  output logic       port_valid_o,
  input  logic       port_ready_i,
  output logic       done_o
);

  logic       active_q, active_d;
  logic [1:0] step_q, step_d;
  logic [7:0] byte_q, byte_d;
  logic       rs_q, rs_d;
  logic [3:0] nib;

  // Nibble-only requests start at step 2 so only the low nibble is strobed.
  always_comb begin
    active_d = active_q;
    step_d   = step_q;
    byte_d   = byte_q;
    rs_d     = rs_q;
    if (!active_q && req_valid_i) begin
      active_d = 1'b1;
      step_d   = req_nib_i ? 2'd2 : 2'd0;
      byte_d   = req_byte_i;
      rs_d     = req_rs_i;
    end else if (active_q && port_ready_i) begin
      step_d = step_q + 2'd1;
      if (step_q == 2'd3) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
      step_q   <= 2'd0;
      byte_q   <= 8'h00;
      rs_q     <= 1'b0;
    end else begin
      active_q <= active_d;
      step_q   <= step_d;
      byte_q   <= byte_d;
      rs_q     <= rs_d;
    end
  end

  assign nib          = step_q[1] ? byte_q[3:0] : byte_q[7:4];
  assign req_ready_o  = !active_q;
  assign port_valid_o = active_q;
  assign done_o       = active_q && port_ready_i && (step_q == 2'd3);

  always_comb begin
    port_data_o = 8'h00;
    if (active_q) begin
      port_data_o[7:4]    = nib;
      port_data_o[BL_BIT] = 1'b1;
      port_data_o[EN_BIT] = ~step_q[0];
      port_data_o[RW_BIT] = 1'b0;
      port_data_o[RS_BIT] = rs_q;
    end
  end

endmodule

// File: rtl/lcd_frame_writer.sv
// rtl/lcd_frame_writer.sv - HD44780 init and frame sequencer over a PCF8574 byte stream
// Optional LCD_CHANGE_ONLY_EN: refresh only when the row inputs differ from the last frame sent.
module lcd_frame_writer
  import lcd_pkg::*;
#(
  parameter int CMD_CYC   = 2_500,
  parameter int CLR_CYC   = 100_000,
  parameter int PWRUP_CYC = 2_500_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] row1,
  input  logic [127:0] row2,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         init_done,
  output logic         frame_done
);

  localparam int MAX_CYC = (PWRUP_CYC > CLR_CYC) ? ((PWRUP_CYC > CMD_CYC) ? PWRUP_CYC : CMD_CYC)
                                                 : ((CLR_CYC > CMD_CYC) ? CLR_CYC : CMD_CYC);
  localparam int CW = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] PWRUP_LOAD = CW'(PWRUP_CYC - 1);
  localparam logic [CW-1:0] CLR_LOAD   = CW'(CLR_CYC - 1);
  localparam logic [CW-1:0] CMD_LOAD   = CW'(CMD_CYC - 1);

  lcd_state_e     state_q, state_d;
  logic [5:0]     idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           waiting_q, waiting_d;
  logic           len_clr_q, len_clr_d;
  logic [127:0]   snap1_q, snap1_d, snap2_q, snap2_d;
  logic           init_done_q, init_done_d;
  logic           frame_done_q, frame_done_d;

  logic       req_valid, req_ready, req_rs, req_nib, req_clr, split_done;
  logic [7:0] req_byte;
  logic       fire, start_frame;
  logic [3:0] ch1_k, ch2_k;

  assign fire  = waiting_q && (cnt_q == '0) && req_ready;
  assign ch1_k = idx_q[3:0] - 4'd1;
  assign ch2_k = idx_q[3:0] - 4'd2;

  // Items are issued the cycle the wait expires so out_valid stays low for exactly the wait.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    waiting_d    = waiting_q;
    len_clr_d    = len_clr_q;
    snap1_d      = snap1_q;
    snap2_d      = snap2_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    req_valid    = 1'b0;
    req_byte     = 8'h00;
    req_rs       = 1'b0;
    req_nib      = 1'b0;
    req_clr      = 1'b0;
    start_frame  = 1'b0;
    if (waiting_q && cnt_q != '0) cnt_d = cnt_q - 1'b1;
    if (fire) begin
      case (state_q)
        ST_PWRUP: begin
          req_valid = 1'b1; req_byte = 8'h03; req_nib = 1'b1; req_clr = 1'b1;
          state_d   = ST_INIT_NIB;
          idx_d     = 6'd1;
        end
        ST_INIT_NIB: begin
          req_valid = 1'b1; req_nib = 1'b1; req_clr = 1'b1;
          req_byte  = (idx_q == 6'd3) ? 8'h02 : 8'h03;
          if (idx_q == 6'd3) begin
            state_d = ST_INIT_CMD;
            idx_d   = 6'd0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
        ST_INIT_CMD: begin
          if (idx_q == 6'd4) begin
            start_frame = 1'b1;
            init_done_d = 1'b1;
          end else begin
            req_valid = 1'b1;
            idx_d     = idx_q + 6'd1;
            case (idx_q[1:0])
              2'd0:    req_byte = CMD_FUNC_4B2L;
              2'd1:    req_byte = CMD_DISP_ON;
              2'd2:    req_byte = CMD_ENTRY_INC;
              default: begin req_byte = CMD_CLEAR; req_clr = 1'b1; end
            endcase
          end
        end
        ST_FRAME: begin
          if (idx_q == 6'd34) begin
            state_d      = ST_GAP;
            frame_done_d = 1'b1;
          end else begin
            req_valid = 1'b1;
            idx_d     = idx_q + 6'd1;
            if (idx_q == 6'd17) begin
              req_byte = DDRAM_L2;
            end else if (idx_q <= 6'd16) begin
              req_byte = row_char(snap1_q, ch1_k); req_rs = 1'b1;
            end else begin
              req_byte = row_char(snap2_q, ch2_k); req_rs = 1'b1;
            end
          end
        end
        ST_GAP: begin
`ifdef LCD_CHANGE_ONLY_EN
          if ({row1, row2} != {snap1_q, snap2_q}) start_frame = 1'b1;
`else
          start_frame = 1'b1;
`endif
        end
        default: state_d = ST_PWRUP;
      endcase
      if (start_frame) begin
        req_valid = 1'b1;
        req_byte  = DDRAM_L1;
        state_d   = ST_FRAME;
        idx_d     = 6'd1;
        snap1_d   = row1;
        snap2_d   = row2;
      end
      if (req_valid) begin
        waiting_d = 1'b0;
        len_clr_d = req_clr;
      end
    end
    if (split_done) begin
      waiting_d = 1'b1;
      cnt_d     = len_clr_q ? CLR_LOAD : CMD_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_PWRUP;
      idx_q        <= 6'd0;
      cnt_q        <= PWRUP_LOAD;
      waiting_q    <= 1'b1;
      len_clr_q    <= 1'b0;
      snap1_q      <= '0;
      snap2_q      <= '0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      waiting_q    <= waiting_d;
      len_clr_q    <= len_clr_d;
      snap1_q      <= snap1_d;
      snap2_q      <= snap2_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  lcd_byte_splitter u_split (
    .clk          (clk),
    .rst          (rst),
    .req_byte_i   (req_byte),
    .req_rs_i     (req_rs),
    .req_nib_i    (req_nib),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .port_data_o  (out_data),
    .port_valid_o (out_valid),
    .port_ready_i (out_ready),
    .done_o       (split_done)
  );

  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// tb/tb_lcd_frame_writer.sv - scoreboard bench for lcd_frame_writer (init, frames, backpressure, reset)
`timescale 1ns/1ps
module tb_lcd_frame_writer;

  localparam int PW = 10;
  localparam int CL = 20;
  localparam int CM = 5;
  localparam int INIT_XFERS = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] row1, row2;
  logic [7:0]   out_data;
  logic         out_valid, out_ready, init_done, frame_done;

  lcd_frame_writer #(.CMD_CYC(CM), .CLR_CYC(CL), .PWRUP_CYC(PW)) dut (
    .clk(clk), .rst(rst), .row1(row1), .row2(row2),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .init_done(init_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; int idle; logic ini; } exp_t;
  typedef struct { string name; int idle; int n; logic [31:0] bytes; } vec_t;

  exp_t exp_q[$];
  vec_t init_tab[8];
  int   total = 0, bad = 0;
  int   xfers = 0, nfd = 0, idle_run = 0;
  bit   mon_en = 0, rnd_ready = 0, stall_prev = 0, fd_prev = 0;
  logic [7:0] data_prev = 8'h00;
  logic [127:0] ra1, ra2, rb1, rb2;

  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", n, g, e);
    end
  endtask

  function automatic logic [7:0] sub(input logic [7:0] c);
    return (c == 8'h00) ? 8'h20 : c;
  endfunction

  task automatic push_byte(input logic [7:0] b, input logic rs, input int idle, input logic ini);
    exp_q.push_back('{{b[7:4], 1'b1, 1'b1, 1'b0, rs}, idle, ini});
    exp_q.push_back('{{b[7:4], 1'b1, 1'b0, 1'b0, rs}, 0, ini});
    exp_q.push_back('{{b[3:0], 1'b1, 1'b1, 1'b0, rs}, 0, ini});
    exp_q.push_back('{{b[3:0], 1'b1, 1'b0, 1'b0, rs}, 0, ini});
  endtask

  task automatic push_frame(input logic [127:0] r1, input logic [127:0] r2, input int first_idle);
    push_byte(8'h80, 1'b0, first_idle, 1'b1);
    for (int k = 0; k < 16; k++) push_byte(sub(r1[127-8*k -: 8]), 1'b1, CM, 1'b1);
    push_byte(8'hC0, 1'b0, CM, 1'b1);
    for (int k = 0; k < 16; k++) push_byte(sub(r2[127-8*k -: 8]), 1'b1, CM, 1'b1);
  endtask

  task automatic push_init();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < init_tab[i].n; j++)
        exp_q.push_back('{init_tab[i].bytes[31-8*j -: 8], (j == 0) ? init_tab[i].idle : 0, 1'b0});
  endtask

  task automatic reset_assert();
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_data", out_data, 8'h00);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_init_done", init_done, 1'b0);
    chk("reset_frame_done", frame_done, 1'b0);
  endtask

  task automatic reset_release();
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic wait_empty(input string n, input int bound);
    int c = 0;
    while (exp_q.size() != 0 && c < bound) begin @(negedge clk); c++; end
    chk(n, exp_q.size(), 0);
  endtask

  task automatic wait_xfers(input int target, input int bound);
    int c = 0;
    while (xfers < target && c < bound) begin @(negedge clk); c++; end
    chk("wait_xfers", (xfers >= target), 1'b1);
  endtask

  // Monitor: sampled on the falling edge, pops the scoreboard on every transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst || !mon_en) begin
      if (!rst) begin idle_run = 0; xfers = 0; nfd = 0; end
      stall_prev = 0; fd_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, data_prev);
      end
      if (frame_done) begin
        chk("frame_done_xfers", xfers, INIT_XFERS + 136 * (nfd + 1));
        nfd++;
      end
      if (fd_prev && frame_done) chk("frame_done_width", 2, 1);
      fd_prev = frame_done;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_byte: got=%0h expected=none", out_data);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("byte%0d", xfers), out_data, e.d);
            if (e.idle >= 0) chk($sformatf("idle%0d", xfers), idle_run, e.idle);
            chk($sformatf("init_done%0d", xfers), init_done, e.ini);
          end
          xfers++;
          idle_run = 0;
        end
      end else begin
        idle_run++;
      end
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    int seen;
    out_ready = 1'b1;
    ra1 = "Temp: 25'C      ";
    ra2 = "Hello World!    ";
    rb1 = "Line one text   ";
    rb2 = "Second line  42 ";
    row1 = ra1;
    row2 = ra2;
    init_tab[0] = '{"nib3a", PW, 2, 32'h3C38_0000};
    init_tab[1] = '{"nib3b", CL, 2, 32'h3C38_0000};
    init_tab[2] = '{"nib3c", CL, 2, 32'h3C38_0000};
    init_tab[3] = '{"nib2",  CL, 2, 32'h2C28_0000};
    init_tab[4] = '{"func",  CL, 4, 32'h2C28_8C88};
    init_tab[5] = '{"disp",  CM, 4, 32'h0C08_CCC8};
    init_tab[6] = '{"entry", CM, 4, 32'h0C08_6C68};
    init_tab[7] = '{"clear", CM, 4, 32'h0C08_1C18};

    // Phase A: init, frame of rows A, rows changed mid-frame feed frame 2.
    reset_assert();
    exp_q.delete();
    push_init();
    push_frame(ra1, ra2, CL);
    push_frame(rb1, rb2, CM + 1);
    mon_en = 1;
    reset_release();
    wait_xfers(INIT_XFERS + 60, 3000);
    row1 = rb1;
    row2 = rb2;
    wait_empty("phaseA_drain", 4000);
    chk("init_done_after_init", init_done, 1'b1);
`ifdef LCD_CHANGE_ONLY_EN
    repeat (200) @(negedge clk);
    chk("static_no_bytes", xfers, INIT_XFERS + 272);
    rb2[7:0] = 8'h41;
    push_frame(rb1, rb2, -1);
    row2 = rb2;
    wait_empty("change_frame", 2000);
    repeat (200) @(negedge clk);
    chk("one_more_frame", xfers, INIT_XFERS + 408);
    chk("frame_count_change", nfd, 3);
    mon_en = 0;
`else
    push_frame(rb1, rb2, CM + 1);
    wait_xfers(INIT_XFERS + 272 + 40, 2000);
    chk("frame_count_refresh", nfd, 2);
    mon_en = 0;
`endif

    // Phase B: reset (mid-frame in refresh mode), blank rows, random backpressure.
    reset_assert();
    row1 = '0;
    row2 = '0;
    exp_q.delete();
    push_init();
    push_frame('0, '0, CL);
    mon_en = 1;
    rnd_ready = 1;
    reset_release();
    wait_empty("phaseB_drain", 6000);
    mon_en = 0;
    seen = 0;
    for (int c = 0; c < CM + 10; c++) begin
      @(negedge clk);
      if (frame_done) seen++;
    end
    chk("frame_done_blank", seen, 1);
    rnd_ready = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
